// File: rtl/duck_pkg.sv
// Duck sprite geometry and the VGA timing+colour bundle used by the duck drawer.
package duck_pkg;

  localparam logic [10:0] DUCK_W      = 11'd96;
  localparam logic [10:0] DUCK_H      = 11'd60;
  localparam int          DUCK_PIXELS = 5760;
  localparam logic [11:0] KEY_COLOR   = 12'hF0F;

  // 38-bit raster bundle carried down the pipeline alongside the sprite lookup
  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

endpackage

// File: rtl/delay.sv
// Parameterised W-bit, DEPTH-stage shift register with synchronous reset.
module delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_duck_ctl.sv
// Duck sprite sequencer: ROM addressing from raster position, 3-clk aligned
// timing pipeline and key-colour overlay onto the incoming rgb stream.
module draw_duck_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        mirror,
  input  logic        enable,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        duck_px
);
  import duck_pkg::*;

  logic [10:0] x_sh, y_sh;
  logic        mir_sh, en_sh, vblnk_prev;

  // Position is only taken at the start of vertical blank so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sh       <= '0;
      y_sh       <= '0;
      mir_sh     <= 1'b0;
      en_sh      <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_sh   <= xpos;
        y_sh   <= ypos;
        mir_sh <= mirror;
        en_sh  <= enable;
      end
    end
  end

  logic [10:0] dx, dy, col;
  logic [12:0] dy13, addr;
  logic        in_box;

  always_comb begin
    dx     = hcount_in - x_sh;
    dy     = vcount_in - y_sh;
    in_box = en_sh && (hcount_in >= x_sh) && (dx < DUCK_W) &&
             (vcount_in >= y_sh) && (dy < DUCK_H) && !hblnk_in && !vblnk_in;
    col    = mir_sh ? (DUCK_W - 11'd1 - dx) : dx;
    dy13   = {2'b00, dy};
    addr   = (dy13 << 6) + (dy13 << 5) + {2'b00, col};
  end

  always_ff @(posedge clk) begin
    if (rst) rom_addr <= '0;
    else     rom_addr <= in_box ? addr : 13'd0;
  end

  vga_t bus_in, bus_c;
  logic in_box_b;

  assign bus_in = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in};

  delay #(.W($bits(vga_t)), .DEPTH(3)) u_tim_dly (
    .clk(clk), .rst(rst), .din(bus_in), .dout(bus_c)
  );

  delay #(.W(1), .DEPTH(2)) u_box_dly (
    .clk(clk), .rst(rst), .din(in_box), .dout(in_box_b)
  );

  // Sprite colour is captured in the final stage; the overlay select is a
  // registered flag, so rgb_out still changes only on the clock edge.
  logic [11:0] sprite_c;
  logic        px;

  assign px = in_box_b && (rom_rgb != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_c <= '0;
      duck_px  <= 1'b0;
    end else begin
      sprite_c <= rom_rgb;
      duck_px  <= px;
    end
  end

  assign rgb_out    = duck_px ? sprite_c : bus_c.rgb;
  assign vcount_out = bus_c.vcount;
  assign vsync_out  = bus_c.vsync;
  assign vblnk_out  = bus_c.vblnk;
  assign hcount_out = bus_c.hcount;
  assign hsync_out  = bus_c.hsync;
  assign hblnk_out  = bus_c.hblnk;

endmodule

// File: doc/draw_duck_ctl.md
Name: draw_duck_ctl

Overview:
Sequences the 96x60 duck sprite ROM, which holds 5760 pixels and has 1-cycle registered read latency, against the VGA raster.
- Computes the ROM address from the raster position and the duck position.
- Compensates the ROM latency by delaying all timing signals.
- Overlays non-transparent sprite pixels onto the incoming rgb stream.
Sits in the draw chain after the background drawer; the ROM is instantiated next to it, and rom_addr/rom_rgb connect directly.

Parameters:
DUCK_W, 96, sprite width in pixels
DUCK_H, 60, sprite height in pixels
KEY_COLOR, 12'hF0F, transparent colour in ROM data; pixel not drawn

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vcount_in  in  11  raster line
vsync_in  in  1  vertical sync
vblnk_in  in  1  vertical blank
hcount_in  in  11  raster column
hsync_in  in  1  horizontal sync
hblnk_in  in  1  horizontal blank
rgb_in  in  12  upstream pixel colour
xpos  in  11  requested duck left edge, screen pixels
ypos  in  11  requested duck top edge, screen pixels
mirror  in  1  requested horizontal flip; 1 = duck faces left
enable  in  1  requested visibility
rom_addr  out  13  ROM address, row*96+col
rom_rgb  in  12  ROM data, valid 1 clk after rom_addr
vcount_out  out  11  vcount_in delayed 3 clk
vsync_out  out  1  delayed 3 clk
vblnk_out  out  1  delayed 3 clk
hcount_out  out  11  delayed 3 clk
hsync_out  out  1  delayed 3 clk
hblnk_out  out  1  delayed 3 clk
rgb_out  out  12  composed pixel, 3 clk latency
duck_px  out  1  1 = rgb_out came from the sprite; aligned with rgb_out; used for hit detection

Behaviour:
Reset:
- All outputs and pipeline registers go to 0.
- Shadow registers go to 0, so enable is off and no duck is drawn until the first blanking update.

Shadow update:
- Registers x_sh, y_sh, mir_sh and en_sh load xpos, ypos, mirror and enable only on the cycle vblnk_in rises (vblnk_in=1 and the previous sample was 0).
- At all other times the inputs are ignored, so no tearing occurs mid-frame.

Stage A (edge 1):
- Combinationally compute dx = hcount_in - x_sh and dy = vcount_in - y_sh, 11-bit unsigned.
- in_box = en_sh & (hcount_in >= x_sh) & (dx < DUCK_W) & (vcount_in >= y_sh) & (dy < DUCK_H) & ~hblnk_in & ~vblnk_in.
- col = mir_sh ? (DUCK_W-1-dx) : dx.
- Register rom_addr <= in_box ? dy*96 + col : 0, computed as (dy<<6)+(dy<<5)+col and truncated to 13 bits; the maximum is 5759.
- Register in_box_a and all timing/rgb signals.

Stage B (edge 2):
- ROM presents rom_rgb.
- Timing, rgb and in_box are delayed one more stage.

Stage C (edge 3):
- px = in_box_b & (rom_rgb != KEY_COLOR).
- rgb_out <= px ? rom_rgb : rgb_b.
- duck_px <= px.
- Timing outputs are registered.

Latency: all outputs are exactly 3 clk after the corresponding inputs.

Boundaries:
- Sprite partially past the right or bottom edge: only on-screen pixels are drawn; no wrap to the next line.
- Positions 0,0 are valid.
- A blanking pixel is never drawn, even when inside the box.
- vblnk rise in the same cycle as rst: rst wins.
- rst mid-frame: pipeline is flushed to 0, the duck is hidden until the next vblnk rise, and timing outputs resume after 3 clk.

Decomposition:
- Add to a shared package duck_pkg: DUCK_W, DUCK_H, DUCK_PIXELS=5760, KEY_COLOR.
- Screen limits come from the existing vga_pkg.
- One natural sub-module: delay, a parameterised width/depth shift register with sync reset.
  - Instance 1: the 38-bit timing+rgb bundle, depth 3.
  - Instance 2: the in_box flag, depth 2.

Test Plan:
1. Shadow position (100,50), enable=1, mirror=0; drive hcount=100, vcount=50 -> rom_addr=0 after 1 clk; with rom_rgb=12'h0A0, rgb_out=12'h0A0 and duck_px=1 after 3 clk.
2. Same position; hcount=195, vcount=109 -> rom_addr=5759. hcount=196 -> out of box: rom_addr=0, rgb_out=rgb_in delayed, duck_px=0.
3. mirror=1; hcount=100, vcount=50 -> rom_addr=95. hcount=195 -> rom_addr=0.
4. rom_rgb=12'hF0F inside box, rgb_in=12'h00F -> rgb_out=12'h00F and duck_px=0 after 3 clk.
5. Change xpos from 100 to 300 mid-frame -> drawing stays at 100 until the vblnk_in rise; the next frame draws at 300. enable=0 latched -> no duck_px for the whole frame.
6. Assert rst for 1 clk mid-line -> all outputs 0 on the following edges; the duck stays hidden until vblnk rises with enable=1. Timing outputs track inputs with 3 clk delay after release.
